// File: rtl/ifid_latch.sv
// IF/ID pipeline register: captures instruction and PC+2, holds on stall, injects NOP on flush/bubble/halt.
// Optional saturating stall-cycle counter enabled by defining STALL_CNT_EN.
module ifid_latch #(
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]        HALT_OPC  = 5'b00000,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [DATA_W-1:0] if_pc_inc,
    input  logic              if_valid,
    input  logic              id_stall,
    input  logic              id_flush,
    output logic [DATA_W-1:0] id_instr,
    output logic [DATA_W-1:0] id_pc_inc,
    output logic              id_valid,
    output logic              halt_seen
`ifdef STALL_CNT_EN
    ,output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [2:0] ACT_LOAD   = 3'd0;
    localparam logic [2:0] ACT_BUBBLE = 3'd1;
    localparam logic [2:0] ACT_FREEZE = 3'd2;
    localparam logic [2:0] ACT_STALL  = 3'd3;
    localparam logic [2:0] ACT_FLUSH  = 3'd4;

    logic [DATA_W-1:0] id_instr_q, id_instr_d;
    logic [DATA_W-1:0] id_pc_inc_q, id_pc_inc_d;
    logic              id_valid_q, id_valid_d;
    logic              halt_seen_q, halt_seen_d;
    logic [2:0]        act_s;
    logic              is_halt_s;

    assign is_halt_s = (if_instr[DATA_W-1 -: 5] == HALT_OPC);

    // Resolve the per-edge action: flush > stall > halt-freeze > load/bubble.
    always_comb begin
        act_s = ACT_LOAD;
        if (id_flush) begin
            act_s = ACT_FLUSH;
        end else if (id_stall) begin
            act_s = ACT_STALL;
        end else if (halt_seen_q) begin
            act_s = ACT_FREEZE;
        end else if (if_valid) begin
            act_s = ACT_LOAD;
        end else begin
            act_s = ACT_BUBBLE;
        end
    end

    // Next-state of the latch; every non-valid outcome forces the NOP encoding.
    always_comb begin
        id_instr_d  = id_instr_q;
        id_pc_inc_d = id_pc_inc_q;
        id_valid_d  = id_valid_q;
        halt_seen_d = halt_seen_q;
        case (act_s)
            ACT_FLUSH: begin
                id_instr_d  = NOP_INSTR;
                id_pc_inc_d = {DATA_W{1'b0}};
                id_valid_d  = 1'b0;
                halt_seen_d = 1'b0;
            end
            ACT_STALL: begin
                id_instr_d  = id_instr_q;
                id_pc_inc_d = id_pc_inc_q;
                id_valid_d  = id_valid_q;
                halt_seen_d = halt_seen_q;
            end
            ACT_FREEZE, ACT_BUBBLE: begin
                id_instr_d  = NOP_INSTR;
                id_valid_d  = 1'b0;
            end
            ACT_LOAD: begin
                id_instr_d  = if_instr;
                id_pc_inc_d = if_pc_inc;
                id_valid_d  = 1'b1;
                halt_seen_d = is_halt_s;
            end
            default: begin
                id_instr_d  = NOP_INSTR;
                id_pc_inc_d = {DATA_W{1'b0}};
                id_valid_d  = 1'b0;
                halt_seen_d = 1'b0;
            end
        endcase
    end

    // Pipeline register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_instr_q  <= NOP_INSTR;
            id_pc_inc_q <= {DATA_W{1'b0}};
            id_valid_q  <= 1'b0;
            halt_seen_q <= 1'b0;
        end else begin
            id_instr_q  <= id_instr_d;
            id_pc_inc_q <= id_pc_inc_d;
            id_valid_q  <= id_valid_d;
            halt_seen_q <= halt_seen_d;
        end
    end

    assign id_instr  = id_instr_q;
    assign id_pc_inc = id_pc_inc_q;
    assign id_valid  = id_valid_q;
    assign halt_seen = halt_seen_q;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             cnt_hit_s;

    // Only stalls holding a real instruction count; the counter never wraps.
    assign cnt_hit_s = id_stall & ~id_flush & id_valid_q;

    // Saturating increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_hit_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter state, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_latch.sv
// Directed plus randomized bench for ifid_latch against a behavioural model of the IF/ID rules.
module tb_ifid_latch;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk;
    logic        rst_n;
    logic [15:0] if_instr;
    logic [15:0] if_pc_inc;
    logic        if_valid;
    logic        id_stall;
    logic        id_flush;
    logic [15:0] id_instr;
    logic [15:0] id_pc_inc;
    logic        id_valid;
    logic        halt_seen;
`ifdef STALL_CNT_EN
    logic [3:0]  stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Behavioural model of the visible register contents.
    logic [15:0] m_instr;
    logic [15:0] m_pc;
    logic        m_valid;
    logic        m_halt;
    int          m_cnt;

    ifid_latch #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_instr  (if_instr),
        .if_pc_inc (if_pc_inc),
        .if_valid  (if_valid),
        .id_stall  (id_stall),
        .id_flush  (id_flush),
        .id_instr  (id_instr),
        .id_pc_inc (id_pc_inc),
        .id_valid  (id_valid),
        .halt_seen (halt_seen)
`ifdef STALL_CNT_EN
        ,.stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_instr"}, {16'h0, id_instr}, {16'h0, m_instr});
        check({tag, "_pc"}, {16'h0, id_pc_inc}, {16'h0, m_pc});
        check({tag, "_valid"}, {31'h0, id_valid}, {31'h0, m_valid});
        check({tag, "_halt"}, {31'h0, halt_seen}, {31'h0, m_halt});
`ifdef STALL_CNT_EN
        check({tag, "_cnt"}, {28'h0, stall_cnt}, m_cnt);
`endif
    endtask

    task automatic model_reset();
        m_instr = NOP;
        m_pc    = 16'h0000;
        m_valid = 1'b0;
        m_halt  = 1'b0;
        m_cnt   = 0;
    endtask

    // Apply the documented edge rules to the model, using the pre-edge model state.
    task automatic model_edge(input logic [15:0] ins, input logic [15:0] pc, input logic v,
                              input logic st, input logic fl);
        if (st && !fl && m_valid && m_cnt < 15) m_cnt = m_cnt + 1;
        if (fl) begin
            m_instr = NOP; m_pc = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
        end else if (st) begin
            m_instr = m_instr;
        end else if (m_halt || !v) begin
            m_instr = NOP; m_valid = 1'b0;
        end else begin
            m_instr = ins; m_pc = pc; m_valid = 1'b1;
            if (ins[15:11] == 5'b00000) m_halt = 1'b1;
        end
    endtask

    task automatic step(input string tag, input logic [15:0] ins, input logic [15:0] pc,
                        input logic v, input logic st, input logic fl);
        @(negedge clk);
        if_instr = ins; if_pc_inc = pc; if_valid = v; id_stall = st; id_flush = fl;
        @(posedge clk);
        model_edge(ins, pc, v, st, fl);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; if_instr = 16'h0; if_pc_inc = 16'h0; if_valid = 1'b0;
        id_stall = 1'b0; id_flush = 1'b0;
        model_reset();
        #12;
        check_all("t1_reset_initial");
        @(negedge clk);
        rst_n = 1'b1;

        step("t2_load", 16'h4123, 16'h0002, 1'b1, 1'b0, 1'b0);
        check("t2_instr_const", {16'h0, id_instr}, 32'h0000_4123);

        for (int i = 0; i < 3; i++) step("t3_stall", 16'h5555, 16'h0004, 1'b1, 1'b1, 1'b0);
        check("t3_instr_held", {16'h0, id_instr}, 32'h0000_4123);
`ifdef STALL_CNT_EN
        check("t3_cnt3", {28'h0, stall_cnt}, 32'd3);
`endif

        step("t4_flush_stall", 16'h5555, 16'h0004, 1'b1, 1'b1, 1'b1);
        check("t4_nop", {16'h0, id_instr}, 32'h0000_0800);

        step("t5_halt_load", 16'h0000, 16'h0004, 1'b1, 1'b0, 1'b0);
        check("t5_halt_set", {31'h0, halt_seen}, 32'd1);
        step("t5_freeze1", 16'h4123, 16'h0006, 1'b1, 1'b0, 1'b0);
        step("t5_freeze2", 16'h4123, 16'h0008, 1'b1, 1'b0, 1'b0);
        check("t5_pc_held", {16'h0, id_pc_inc}, 32'h0000_0004);
        step("t5_flush", 16'h4123, 16'h0008, 1'b1, 1'b0, 1'b1);
        check("t5_halt_clr", {31'h0, halt_seen}, 32'd0);
        step("t5_reload", 16'h4123, 16'h000a, 1'b1, 1'b0, 1'b0);

        step("t6_bubble", 16'h7777, 16'h000c, 1'b0, 1'b0, 1'b0);
        check("t6_pc_held", {16'h0, id_pc_inc}, 32'h0000_000a);
        step("t6_reload", 16'h6001, 16'h000e, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("t6_sat", 16'h1234, 16'h0010, 1'b1, 1'b1, 1'b0);
`ifdef STALL_CNT_EN
        check("t6_cnt_sat", {28'h0, stall_cnt}, 32'd15);
`endif

        // Reset landing in the middle of a stall, then a normal first load.
        @(negedge clk);
        id_stall = 1'b1; if_valid = 1'b1;
        async_reset("rst_mid_stall");
        step("rst_first_load", 16'h3abc, 16'h0020, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [15:0] ins;
            ins = $urandom_range(0, 7) == 0 ? 16'(($urandom & 32'h07ff)) : 16'($urandom);
            step("rand", ins, 16'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
